stc_out_drain: RTL and testbench

//  Downstream drain for stc_core. Captures each result row presented on out_valid/out_d.

---
 rtl/stc_out_drain.sv | 175 +++++++++++++++++
 tb/tb_stc_out_drain.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/stc_out_drain.sv
// Drain for stc_core result rows: buffers rows in a small FIFO and writes each
// one as a single memory beat at sequential row addresses, pulsing done after M rows.
module stc_out_drain #(
    parameter int unsigned M          = 16,
    parameter int unsigned N          = 16,
    parameter int unsigned DW_DATA    = 16,
    parameter int unsigned DW_MEM     = 256,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned ROW_STRIDE = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [ADDR_W-1:0]        base_addr,
    input  logic                     in_valid,
    input  logic [N*DW_DATA-1:0]     in_d,
    output logic                     mem_wvalid,
    input  logic                     mem_wready,
    output logic [ADDR_W-1:0]        mem_waddr,
    output logic [DW_MEM-1:0]        mem_wdata,
    output logic                     busy,
    output logic                     done,
    output logic                     overflow,
    output logic [$clog2(M+1)-1:0]   rows_written
);

    localparam int unsigned CNT_W = $clog2(M + 1);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned OCC_W = PTR_W + 1;

    localparam logic [CNT_W-1:0]  M_C      = CNT_W'(M);
    localparam logic [CNT_W-1:0]  M_LAST_C = CNT_W'(M - 1);
    localparam logic [OCC_W-1:0]  DEPTH_C  = OCC_W'(FIFO_DEPTH);
    localparam logic [ADDR_W-1:0] STRIDE_C = ADDR_W'(ROW_STRIDE);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q;
    state_t             state_n;
    logic [ADDR_W-1:0]  base_q;
    logic [ADDR_W-1:0]  base_n;
    logic [CNT_W-1:0]   in_cnt_q;
    logic [CNT_W-1:0]   in_cnt_n;
    logic [CNT_W-1:0]   rows_n;
    logic               ovf_n;
    logic               push;
    logic               pop;
    logic               full;

    logic [DW_MEM-1:0]  fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   wr_ptr_n;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_n;
    logic [OCC_W-1:0]   occ_q;
    logic [OCC_W-1:0]   occ_n;
    logic [DW_MEM-1:0]  head_n;

    assign pop  = mem_wvalid & mem_wready;
    assign full = (occ_q == DEPTH_C);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_n;
        end
    end

    // Next-state, push/drop decision and tile counters
    always_comb begin
        state_n  = state_q;
        base_n   = base_q;
        in_cnt_n = in_cnt_q;
        rows_n   = rows_written;
        ovf_n    = overflow;
        push     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_n  = S_RUN;
                    base_n   = base_addr;
                    in_cnt_n = '0;
                    rows_n   = '0;
                    ovf_n    = 1'b0;
                end
            end
            S_RUN: begin
                if (in_valid) begin
                    if ((in_cnt_q < M_C) && (!full || pop)) begin
                        push     = 1'b1;
                        in_cnt_n = in_cnt_q + CNT_W'(1);
                    end else begin
                        ovf_n = 1'b1;
                    end
                end
                if (pop) begin
                    rows_n = rows_written + CNT_W'(1);
                    if (rows_written == M_LAST_C) begin
                        state_n = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // FIFO pointer/occupancy update and next head; a push into an empty slot bypasses storage
    always_comb begin
        wr_ptr_n = push ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
        rd_ptr_n = pop  ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
        occ_n    = occ_q;
        unique case ({push, pop})
            2'b10:   occ_n = occ_q + OCC_W'(1);
            2'b01:   occ_n = occ_q - OCC_W'(1);
            default: occ_n = occ_q;
        endcase
        if (push && (wr_ptr_q == rd_ptr_n)) begin
            head_n = in_d;
        end else begin
            head_n = fifo_mem[rd_ptr_n];
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= in_d;
        end
    end

    // Registered datapath and outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            base_q       <= '0;
            in_cnt_q     <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            occ_q        <= '0;
            mem_wvalid   <= 1'b0;
            mem_waddr    <= '0;
            mem_wdata    <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            overflow     <= 1'b0;
            rows_written <= '0;
        end else begin
            base_q       <= base_n;
            in_cnt_q     <= in_cnt_n;
            wr_ptr_q     <= wr_ptr_n;
            rd_ptr_q     <= rd_ptr_n;
            occ_q        <= occ_n;
            mem_wvalid   <= (occ_n != '0);
            mem_waddr    <= base_n + (ADDR_W'(rows_n) * STRIDE_C);
            if (occ_n != '0) begin
                mem_wdata <= head_n;
            end
            busy         <= (state_n == S_RUN);
            done         <= (state_n == S_DONE);
            overflow     <= ovf_n;
            rows_written <= rows_n;
        end
    end

endmodule

// File: tb/tb_stc_out_drain.sv
// Bench for stc_out_drain: directed vector table, directed tiles and a
// randomized run, all cross-checked against a queue-based transaction model.
module tb_stc_out_drain;

    localparam int M      = 16;
    localparam int DEPTH  = 4;
    localparam int STRIDE = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [31:0]  base_addr;
    logic         in_valid;
    logic [255:0] in_d;
    logic         mem_wvalid;
    logic         mem_wready;
    logic [31:0]  mem_waddr;
    logic [255:0] mem_wdata;
    logic         busy;
    logic         done;
    logic         overflow;
    logic [4:0]   rows_written;

    always #5 clk = ~clk;

    stc_out_drain dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .base_addr    (base_addr),
        .in_valid     (in_valid),
        .in_d         (in_d),
        .mem_wvalid   (mem_wvalid),
        .mem_wready   (mem_wready),
        .mem_waddr    (mem_waddr),
        .mem_wdata    (mem_wdata),
        .busy         (busy),
        .done         (done),
        .overflow     (overflow),
        .rows_written (rows_written)
    );

    int checks = 0;
    int errors = 0;

    // Transaction model: tile phase flags, a queue of buffered rows and counters
    bit           m_run;
    bit           m_done;
    bit           m_ov;
    int           m_in_cnt;
    int           m_written;
    logic [31:0]  m_base;
    logic [255:0] m_q[$];

    logic [31:0]  cap_addr[$];
    logic [255:0] cap_data[$];
    logic [255:0] sent[$];
    int           done_cnt;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] row_data(input int r);
        logic [15:0] e;
        e = 16'(r);
        return {16{e}};
    endfunction

    function automatic logic [255:0] rnd256();
        return {$urandom, $urandom, $urandom, $urandom,
                $urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic model_step();
        bit pop;
        bit was_full;
        if (reset) begin
            m_q.delete();
            m_run = 0; m_done = 0; m_ov = 0; m_in_cnt = 0; m_written = 0;
        end else if (m_run) begin
            pop      = (m_q.size() > 0) && mem_wready;
            was_full = (m_q.size() == DEPTH);
            if (pop) begin
                void'(m_q.pop_front());
                m_written++;
            end
            if (in_valid) begin
                if (m_in_cnt < M && (!was_full || pop)) begin
                    m_q.push_back(in_d);
                    m_in_cnt++;
                end else begin
                    m_ov = 1;
                end
            end
            if (m_written == M) begin
                m_run  = 0;
                m_done = 1;
            end
        end else if (m_done) begin
            m_done = 0;
        end else if (start) begin
            m_run = 1; m_base = base_addr; m_in_cnt = 0; m_written = 0; m_ov = 0;
        end
    endtask

    // One clock: record accepted beat, advance model, sample after the edge
    task automatic tick();
        if (mem_wvalid === 1'b1 && mem_wready) begin
            cap_addr.push_back(mem_waddr);
            cap_data.push_back(mem_wdata);
        end
        model_step();
        @(posedge clk);
        #1;
        chk("m_wvalid", 256'(mem_wvalid), 256'(m_q.size() > 0));
        chk("m_busy", 256'(busy), 256'(m_run));
        chk("m_done", 256'(done), 256'(m_done));
        chk("m_overflow", 256'(overflow), 256'(m_ov));
        chk("m_rows", 256'(rows_written), 256'(m_written));
        if (m_q.size() > 0) begin
            chk("m_waddr", 256'(mem_waddr), 256'(32'(m_base + 32'(m_written * STRIDE))));
            chk("m_wdata", mem_wdata, m_q[0]);
        end
        if (done === 1'b1) done_cnt++;
    endtask

    // Start a tile, feed nrows back to back with wready=1, then verify the beats
    task automatic run_tile(input logic [31:0] base, input int nrows, input bit exp_ov);
        cap_addr.delete(); cap_data.delete(); sent.delete();
        done_cnt   = 0;
        start      = 1'b1;
        base_addr  = base;
        in_valid   = 1'b0;
        mem_wready = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < nrows; k++) begin
            in_valid = 1'b1;
            in_d     = rnd256();
            if (k < M) sent.push_back(in_d);
            tick();
        end
        in_valid = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (done_cnt > 0 && busy === 1'b0) break;
            tick();
        end
        chk("tile_done_pulses", 256'(done_cnt), 256'(1));
        chk("tile_beats", 256'(cap_addr.size()), 256'(M));
        chk("tile_rows_written", 256'(rows_written), 256'(M));
        chk("tile_overflow", 256'(overflow), 256'(exp_ov));
        chk("tile_busy", 256'(busy), 256'(0));
        for (int i = 0; i < M && i < cap_addr.size(); i++) begin
            chk($sformatf("tile_addr%0d", i), 256'(cap_addr[i]), 256'(32'(base + 32'(i * STRIDE))));
            chk($sformatf("tile_data%0d", i), cap_data[i], sent[i]);
        end
        tick();
    endtask

    typedef struct {
        bit          rst;
        bit          st;
        logic [31:0] base;
        bit          iv;
        int          row;
        bit          wr;
        bit          e_wv;
        int          e_row;
        logic [31:0] e_addr;
        bit          e_busy;
        bit          e_done;
        bit          e_ov;
        int          e_rows;
    } vec_t;

    vec_t tbl[13];

    initial begin
        //            rst st base        iv row wr  wv erow addr       bsy dn ov rows
        tbl[0]  = '{0, 1, 32'h1000, 0, 0, 0,  0, 0, 32'h0,    1, 0, 0, 0};
        tbl[1]  = '{0, 0, 32'h0,    1, 1, 0,  1, 1, 32'h1000, 1, 0, 0, 0};
        tbl[2]  = '{0, 0, 32'h0,    1, 2, 0,  1, 1, 32'h1000, 1, 0, 0, 0};
        tbl[3]  = '{0, 0, 32'h0,    1, 3, 0,  1, 1, 32'h1000, 1, 0, 0, 0};
        tbl[4]  = '{0, 0, 32'h0,    1, 4, 0,  1, 1, 32'h1000, 1, 0, 0, 0};
        tbl[5]  = '{0, 0, 32'h0,    1, 5, 1,  1, 2, 32'h1020, 1, 0, 0, 1};
        tbl[6]  = '{0, 0, 32'h0,    1, 6, 0,  1, 2, 32'h1020, 1, 0, 1, 1};
        tbl[7]  = '{0, 0, 32'h0,    1, 7, 0,  1, 2, 32'h1020, 1, 0, 1, 1};
        tbl[8]  = '{0, 0, 32'h0,    0, 0, 1,  1, 3, 32'h1040, 1, 0, 1, 2};
        tbl[9]  = '{0, 0, 32'h0,    0, 0, 1,  1, 4, 32'h1060, 1, 0, 1, 3};
        tbl[10] = '{0, 0, 32'h0,    0, 0, 1,  1, 5, 32'h1080, 1, 0, 1, 4};
        tbl[11] = '{0, 0, 32'h0,    0, 0, 1,  0, 0, 32'h0,    1, 0, 1, 5};
        tbl[12] = '{1, 0, 32'h0,    1, 9, 1,  0, 0, 32'h0,    0, 0, 0, 0};

        reset = 1'b1; start = 1'b0; base_addr = '0; in_valid = 1'b0;
        in_d = '0; mem_wready = 1'b0; done_cnt = 0;
        m_base = '0;
        tick();
        tick();
        chk("rst_wvalid", 256'(mem_wvalid), 256'(0));
        chk("rst_waddr", 256'(mem_waddr), 256'(0));
        chk("rst_wdata", mem_wdata, 256'(0));
        chk("rst_busy", 256'(busy), 256'(0));
        chk("rst_done", 256'(done), 256'(0));
        chk("rst_overflow", 256'(overflow), 256'(0));
        chk("rst_rows", 256'(rows_written), 256'(0));
        reset = 1'b0;

        // Backpressure, full-with-pop accept, drops, drain order, then mid-tile reset
        for (int i = 0; i < 13; i++) begin
            reset      = tbl[i].rst;
            start      = tbl[i].st;
            base_addr  = tbl[i].base;
            in_valid   = tbl[i].iv;
            in_d       = row_data(tbl[i].row);
            mem_wready = tbl[i].wr;
            tick();
            chk($sformatf("t%0d_wvalid", i), 256'(mem_wvalid), 256'(tbl[i].e_wv));
            chk($sformatf("t%0d_busy", i), 256'(busy), 256'(tbl[i].e_busy));
            chk($sformatf("t%0d_done", i), 256'(done), 256'(tbl[i].e_done));
            chk($sformatf("t%0d_overflow", i), 256'(overflow), 256'(tbl[i].e_ov));
            chk($sformatf("t%0d_rows", i), 256'(rows_written), 256'(tbl[i].e_rows));
            if (tbl[i].e_wv || tbl[i].rst) begin
                chk($sformatf("t%0d_wdata", i), mem_wdata, row_data(tbl[i].e_row));
                chk($sformatf("t%0d_waddr", i), 256'(mem_waddr), 256'(tbl[i].e_addr));
            end
        end
        reset = 1'b0; start = 1'b0; in_valid = 1'b0; mem_wready = 1'b0;
        tick();

        run_tile(32'h0000_2000, 16, 1'b0);
        run_tile(32'h0000_1000, 16, 1'b0);
        run_tile(32'h0000_1000, 17, 1'b1);
        run_tile(32'hFFFF_FFF0, 16, 1'b0);
        chk("wrap_addr0", 256'(cap_addr.size() > 0 ? cap_addr[0] : 32'hDEAD), 256'(32'hFFFF_FFF0));
        chk("wrap_addr1", 256'(cap_addr.size() > 1 ? cap_addr[1] : 32'hDEAD), 256'(32'h0000_0010));

        for (int c = 0; c < 3000; c++) begin
            reset      = ($urandom_range(0, 299) == 0);
            start      = ($urandom_range(0, 15) == 0);
            base_addr  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FF00 + 32'($urandom_range(0, 255)))
                                                     : $urandom;
            in_valid   = ($urandom_range(0, 9) < 6);
            in_d       = rnd256();
            mem_wready = ($urandom_range(0, 9) < 6);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
